// File: rtl/acc_pkg.sv
// Shared types and constants for the acc_seq fetch/execute sequencer.
// Optional build macro used by acc_alu: ACC_ONES_COMP_EN (ones' complement AD).
package acc_pkg;

  localparam int unsigned AW = 12;   // address width
  localparam int unsigned DW = 16;   // memory data width, MSB ignored
  localparam int unsigned IW = 15;   // instruction / accumulator width

  localparam logic [AW-1:0] BOOT_ADDR_DEFAULT = 12'h800;

  localparam logic [2:0] OP_TC   = 3'd0;
  localparam logic [2:0] OP_CA   = 3'd3;
  localparam logic [2:0] OP_AD   = 3'd6;
  localparam logic [2:0] OP_MASK = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FWAIT,
    ST_DECODE,
    ST_OREAD,
    ST_OWAIT,
    ST_EXEC
  } state_e;

  // Instruction word as held in G: 3-bit opcode over a 12-bit operand address.
  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] k;
  } instr_t;

endpackage

// File: rtl/acc_if.sv
// Read-only memory port shared with the ROM; master side is the sequencer.
interface acc_if;
  import acc_pkg::*;

  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ack);

endinterface

// File: rtl/acc_alu.sv
// Combinational accumulator datapath for CA / AD / MASK.
// ACC_ONES_COMP_EN selects ones' complement AD with end-around carry.
module acc_alu
  import acc_pkg::*;
(
  input  logic [2:0]    op_i,
  input  logic [IW-1:0] a_i,
  input  logic [IW-1:0] opnd_i,
  output logic [IW-1:0] result_c_o
);

`ifdef ACC_ONES_COMP_EN
  logic [IW:0] sum_c;
`endif
  logic [IW-1:0] add_c;

  // Adder: end-around carry cannot ripple a second time, so one fold suffices.
  always_comb begin
`ifdef ACC_ONES_COMP_EN
    sum_c = (IW+1)'(a_i) + (IW+1)'(opnd_i);
    add_c = sum_c[IW-1:0] + IW'(sum_c[IW]);
`else
    add_c = a_i + opnd_i;
`endif
  end

  // Result select by opcode; unknown opcodes leave A unchanged.
  always_comb begin
    result_c_o = a_i;
    case (op_i)
      OP_CA:   result_c_o = opnd_i;
      OP_AD:   result_c_o = add_c;
      OP_MASK: result_c_o = a_i & opnd_i;
      default: result_c_o = a_i;
    endcase
  end

endmodule

// File: rtl/acc_seq.sv
// Fetch/decode/execute sequencer over a 12-bit address space.
// Optional build macro (inside acc_alu): ACC_ONES_COMP_EN.
module acc_seq
  import acc_pkg::*;
#(
  parameter logic [AW-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          step,
  input  logic          run,
  acc_if.master         bus,
  output logic [AW-1:0] S,
  output logic [IW-1:0] G,
  output logic [IW-1:0] A,
  output logic [AW-1:0] Q,
  output logic          busy,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [AW-1:0] s_q, s_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] a_q, a_d;
  logic [AW-1:0] q_q, q_d;
  logic [IW-1:0] opnd_q, opnd_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;

  instr_t        ir;
  logic [IW-1:0] alu_c;
  logic          unused_rdata_msb;

  assign ir               = instr_t'(g_q);
  assign unused_rdata_msb = bus.mem_rdata[DW-1];

  acc_alu u_alu (
    .op_i       (ir.op),
    .a_i        (a_q),
    .opnd_i     (opnd_q),
    .result_c_o (alu_c)
  );

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      s_q        <= BOOT_ADDR;
      g_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      opnd_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      g_q        <= g_d;
      a_q        <= a_d;
      q_q        <= q_d;
      opnd_q     <= opnd_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  // Next state; mem_rd/mem_addr are set on entry to FETCH/OREAD and held until ack.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    g_d        = g_q;
    a_d        = a_q;
    q_d        = q_q;
    opnd_d     = opnd_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    halted_d   = halted_q;

    case (state_q)
      ST_IDLE: begin
        if ((run || step) && !halted_q) begin
          state_d    = ST_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = s_q;
        end
      end
      ST_FETCH: state_d = ST_FWAIT;
      ST_FWAIT: begin
        if (bus.mem_ack) begin
          g_d      = bus.mem_rdata[IW-1:0];
          s_d      = AW'(s_q + AW'(1));
          mem_rd_d = 1'b0;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        case (ir.op)
          OP_TC: begin
            q_d = s_q;
            s_d = ir.k;
            if (ir.k == AW'(s_q - AW'(1))) halted_d = 1'b1;
          end
          OP_CA, OP_AD, OP_MASK: begin
            state_d    = ST_OREAD;
            mem_rd_d   = 1'b1;
            mem_addr_d = ir.k;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_OREAD: state_d = ST_OWAIT;
      ST_OWAIT: begin
        if (bus.mem_ack) begin
          opnd_d   = bus.mem_rdata[IW-1:0];
          mem_rd_d = 1'b0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        a_d     = alu_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign S            = s_q;
  assign G            = g_q;
  assign A            = a_q;
  assign Q            = q_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq: stepped vector table plus multi-cycle corner sequences.
module tb_acc_seq;
  import acc_pkg::*;

  logic          clk_in;
  logic          rst_in;
  logic          step;
  logic          run;
  logic [AW-1:0] s_w;
  logic [IW-1:0] g_w;
  logic [IW-1:0] a_w;
  logic [AW-1:0] q_w;
  logic          busy_w;
  logic          halted_w;

  acc_if bus ();

  acc_seq #(.BOOT_ADDR(12'h800)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .step   (step),
    .run    (run),
    .bus    (bus),
    .S      (s_w),
    .G      (g_w),
    .A      (a_w),
    .Q      (q_w),
    .busy   (busy_w),
    .halted (halted_w)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay cycles of mem_rd; inject_req forces a stray ack.
  logic [15:0] mem [0:4095];
  int ack_delay  = 1;
  int inject_req = 0;

  initial begin
    int cnt;
    int inject_done;
    cnt = 0;
    inject_done = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk_in);
      bus.mem_ack = 1'b0;
      if (inject_req != inject_done) begin
        inject_done   = inject_req;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h3810;
      end else if (rst_in || !bus.mem_rd) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt > ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          cnt = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Pulse step for one cycle, return cycles until busy drops.
  task automatic run_step(output int cyc);
    @(negedge clk_in);
    step = 1'b1;
    @(negedge clk_in);
    step = 1'b0;
    cyc = 1;
    while (busy_w && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
    end
  endtask

`ifdef ACC_ONES_COMP_EN
  localparam logic [IW-1:0] EXP_OVF = 15'h0001;
  localparam logic [IW-1:0] EXP_R8  = 15'h7FFF;
`else
  localparam logic [IW-1:0] EXP_OVF = 15'h0000;
  localparam logic [IW-1:0] EXP_R8  = 15'h7FFE;
`endif

  typedef struct {
    logic [11:0] pc;
    logic [15:0] instr;
    logic [15:0] opnd;
    logic [14:0] exp_g;
    logic [14:0] exp_a;
    logic [11:0] exp_s;
    logic [11:0] exp_q;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc;
    int rd_seen;
    int rises;
    int unstable;
    logic prev_rd;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] addr0, addr1;
    logic [2:0] op;

    rst_in = 1'b1;
    step   = 1'b0;
    run    = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    //          pc       instr     opnd      G         A         S        Q        cyc
    vecs[0] = '{12'h800, 16'h3810, 16'h1234, 15'h3810, 15'h1234, 12'h801, 12'h000, 7};
    vecs[1] = '{12'h801, 16'h6811, 16'h0005, 15'h6811, 15'h1239, 12'h802, 12'h000, 7};
    vecs[2] = '{12'h802, 16'h7812, 16'h00F0, 15'h7812, 15'h0030, 12'h803, 12'h000, 7};
    vecs[3] = '{12'h803, 16'h1123, 16'h0000, 15'h1123, 15'h0030, 12'h804, 12'h000, 4};
    vecs[4] = '{12'h804, 16'hB813, 16'hFFFF, 15'h3813, 15'h7FFF, 12'h805, 12'h000, 7};
    vecs[5] = '{12'h805, 16'h6814, 16'h0001, 15'h6814, EXP_OVF,  12'h806, 12'h000, 7};
    vecs[6] = '{12'h806, 16'h0900, 16'h0000, 15'h0900, EXP_OVF,  12'h900, 12'h807, 4};
    vecs[7] = '{12'h900, 16'h6815, 16'h7FFE, 15'h6815, EXP_R8,   12'h901, 12'h807, 7};

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_S", 32'(s_w), 32'h800);
    chk("rst_G", 32'(g_w), 32'h0);
    chk("rst_A", 32'(a_w), 32'h0);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_halted", 32'(halted_w), 32'h0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    rst_in = 1'b0;

    // Single-stepped instruction table
    for (int i = 0; i < 8; i++) begin
      mem[vecs[i].pc] = vecs[i].instr;
      op = vecs[i].instr[14:12];
      if (op == OP_CA || op == OP_AD || op == OP_MASK)
        mem[vecs[i].instr[11:0]] = vecs[i].opnd;
    end
    for (int i = 0; i < 8; i++) begin
      run_step(cyc);
      chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_G", i), 32'(g_w), 32'(vecs[i].exp_g));
      chk($sformatf("v%0d_A", i), 32'(a_w), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d_S", i), 32'(s_w), 32'(vecs[i].exp_s));
      chk($sformatf("v%0d_Q", i), 32'(q_w), 32'(vecs[i].exp_q));
    end

    // Run mode: CA 810 / AD 811 / TC 800, then stop after the TC
    do_reset();
    mem[12'h800] = 16'h3810;
    mem[12'h801] = 16'h6811;
    mem[12'h802] = 16'h0800;
    mem[12'h810] = 16'h1234;
    mem[12'h811] = 16'h0005;
    @(negedge clk_in);
    run = 1'b1;
    cyc = 0;
    while (q_w != 12'h803 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
    end
    run = 1'b0;
    chk("run_cyc", 32'(cyc), 32'd18);
    @(negedge clk_in);
    chk("run_S", 32'(s_w), 32'h800);
    chk("run_A", 32'(a_w), 32'h1239);
    chk("run_Q", 32'(q_w), 32'h803);
    @(negedge clk_in);
    chk("run_stop_busy", 32'(busy_w), 32'h0);
    chk("run_stop_rd", 32'(bus.mem_rd), 32'h0);

    // TC-to-self halts; later steps issue no fetch
    do_reset();
    mem[12'h800] = 16'h0805;
    mem[12'h805] = 16'h0805;
    run_step(cyc);
    chk("tc_jump_S", 32'(s_w), 32'h805);
    chk("tc_jump_halted", 32'(halted_w), 32'h0);
    run_step(cyc);
    chk("halt_S", 32'(s_w), 32'h805);
    chk("halt_flag", 32'(halted_w), 32'h1);
    rd_seen = 0;
    @(negedge clk_in);
    step = 1'b1;
    @(negedge clk_in);
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_rd || busy_w) rd_seen++;
      @(negedge clk_in);
    end
    chk("halt_no_fetch", 32'(rd_seen), 32'd0);
    chk("halt_sticky", 32'(halted_w), 32'h1);
    do_reset();
    chk("halt_cleared", 32'(halted_w), 32'h0);

    // Reset during FWAIT with ack withheld; late ack must be ignored
    mem[12'h800] = 16'h3810;
    mem[12'h810] = 16'h1234;
    run_step(cyc);
    chk("rw_G_before", 32'(g_w), 32'h3810);
    ack_delay = 1000;
    @(negedge clk_in);
    step = 1'b1;
    @(negedge clk_in);
    step = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rw_rd_pending", 32'(bus.mem_rd), 32'h1);
    chk("rw_addr_pending", 32'(bus.mem_addr), 32'h801);
    #2 rst_in = 1'b1;
    #1;
    chk("rw_rd_drop", 32'(bus.mem_rd), 32'h0);
    chk("rw_S", 32'(s_w), 32'h800);
    chk("rw_G", 32'(g_w), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    inject_req++;
    repeat (4) @(negedge clk_in);
    chk("rw_late_busy", 32'(busy_w), 32'h0);
    chk("rw_late_G", 32'(g_w), 32'h0);
    chk("rw_late_S", 32'(s_w), 32'h800);
    ack_delay = 1;

    // Slow ack, dropped step while busy, S wrap FFF -> 000
    do_reset();
    mem[12'h800] = 16'h0FFF;
    mem[12'hFFF] = 16'h3810;
    mem[12'h810] = 16'h0042;
    run_step(cyc);
    chk("wrap_jump_S", 32'(s_w), 32'hFFF);
    ack_delay = 5;
    rises = 0;
    unstable = 0;
    prev_rd = 1'b0;
    prev_addr = '0;
    addr0 = '0;
    addr1 = '0;
    @(negedge clk_in);
    step = 1'b1;
    cyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_in);
      cyc++;
      step = (i == 4) ? 1'b1 : 1'b0;
      if (bus.mem_rd && !prev_rd) begin
        if (rises == 0) addr0 = bus.mem_addr;
        if (rises == 1) addr1 = bus.mem_addr;
        rises++;
      end
      if (bus.mem_rd && prev_rd && bus.mem_addr != prev_addr) unstable++;
      prev_rd   = bus.mem_rd;
      prev_addr = bus.mem_addr;
      if (!busy_w && i > 5) break;
    end
    step = 1'b0;
    chk("slow_idle", 32'(busy_w), 32'h0);
    chk("slow_addr_stable", 32'(unstable), 32'd0);
    chk("slow_req_count", 32'(rises), 32'd2);
    chk("slow_fetch_addr", 32'(addr0), 32'hFFF);
    chk("slow_opnd_addr", 32'(addr1), 32'h810);
    chk("slow_S_wrap", 32'(s_w), 32'h000);
    chk("slow_A", 32'(a_w), 32'h0042);
    repeat (5) @(negedge clk_in);
    chk("slow_no_queue", 32'(busy_w), 32'h0);
    ack_delay = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
